// File: rtl/hh_fixed_pkg.sv
// Fixed-point formats, HH constants and shared types for the membrane and gate blocks.
package hh_fixed_pkg;

  localparam int unsigned V_W      = 16;  // signed Q8.8 mV
  localparam int unsigned G_W      = 16;  // unsigned Q0.16 gating
  localparam int unsigned I_W      = 24;  // signed Q16.8 uA/cm^2
  localparam int unsigned DT_SHIFT = 6;   // dt/C = 2^-6

  localparam int unsigned OP_W   = 18;    // multiplier operand width
  localparam int unsigned PROD_W = 36;    // full product width
  localparam int unsigned DIFF_W = 17;    // V - E difference width
  localparam int unsigned SUM_W  = 27;    // current summation headroom
  localparam int unsigned UPD_W  = 25;    // V + dV headroom before clamp
  localparam int unsigned CNT_W  = 4;     // MUL step counter width

  localparam int unsigned SH_HI = 16;
  localparam int unsigned SH_LO = 8;

  // Conductances, Q8.8 mS/cm^2
  localparam logic signed [V_W-1:0] G_NA = 16'sd30720;
  localparam logic signed [V_W-1:0] G_K  = 16'sd9216;
  localparam logic signed [V_W-1:0] G_L  = 16'sd77;

  // Reversal potentials and membrane limits, Q8.8 mV
  localparam logic signed [V_W-1:0] E_NA     =  16'sd12800;
  localparam logic signed [V_W-1:0] E_K      = -16'sd19712;
  localparam logic signed [V_W-1:0] E_L      = -16'sd13923;
  localparam logic signed [V_W-1:0] V_REST   = -16'sd16640;
  localparam logic signed [V_W-1:0] V_MIN    = -16'sd25600;
  localparam logic signed [V_W-1:0] V_MAX    =  16'sd15360;
  localparam logic signed [V_W-1:0] SPIKE_TH =  16'sd0;

  localparam logic signed [I_W-1:0] I_MAX = {1'b0, {(I_W-1){1'b1}}};
  localparam logic signed [I_W-1:0] I_MIN = {1'b1, {(I_W-1){1'b0}}};

  // MUL schedule landmarks
  localparam logic [CNT_W-1:0] STEP_NA_CAP = 4'd5;   // I_Na product visible
  localparam logic [CNT_W-1:0] STEP_K_CAP  = 4'd10;  // I_K product visible
  localparam logic [CNT_W-1:0] STEP_LAST   = 4'd11;  // drain slot, I_L visible

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2,
    ST_UPD  = 2'd3
  } hh_state_e;

  typedef enum logic {
    SH_8  = 1'b0,
    SH_16 = 1'b1
  } mul_shift_e;

  typedef struct packed {
    logic [G_W-1:0]        m;
    logic [G_W-1:0]        h;
    logic [G_W-1:0]        n;
    logic signed [I_W-1:0] i_ext;
  } hh_gate_in_t;

  // Clamp a wide current sum into the I_W signed range.
  function automatic logic signed [I_W-1:0] sat_i(input logic signed [SUM_W-1:0] x);
    if (x > SUM_W'(I_MAX))      sat_i = I_MAX;
    else if (x < SUM_W'(I_MIN)) sat_i = I_MIN;
    else                        sat_i = I_W'(x);
  endfunction

endpackage

// File: rtl/hh_membrane_update_mul.sv
// Signed 18x18 multiplier with registered, arithmetically shifted result.
module hh_fx_mul
  import hh_fixed_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [OP_W-1:0] a,
  input  logic signed [OP_W-1:0] b,
  input  mul_shift_e             sh,
  output logic signed [I_W-1:0]  p
);

  logic signed [PROD_W-1:0] prod_c;

  // Full-width product; both operands sign-extended first.
  always_comb begin
    prod_c = PROD_W'(a) * PROD_W'(b);
  end

  // Register the truncated result so a chained product is ready next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
    end else begin
      p <= I_W'((sh == SH_16) ? (prod_c >>> SH_HI) : (prod_c >>> SH_LO));
    end
  end

endmodule

// File: rtl/hh_membrane_update.sv
// Forward-Euler HH membrane integrator on a single time-shared multiplier.
module hh_membrane_update
  import hh_fixed_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [G_W-1:0]        m_in,
  input  logic [G_W-1:0]        h_in,
  input  logic [G_W-1:0]        n_in,
  input  logic signed [I_W-1:0] i_ext,
  output logic signed [V_W-1:0] v_out,
  output logic                  v_valid,
  output logic                  spike
);

  hh_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  v_valid_q, v_valid_d;
  logic                  spike_q, spike_d;
  logic                  accept;

  hh_gate_in_t           gate_q;
  logic signed [V_W-1:0] v_q, v_snap_q;
  logic signed [I_W-1:0] i_na_q, i_k_q, i_l_q, i_tot_q;

  logic signed [OP_W-1:0]   mul_a, mul_b;
  mul_shift_e               mul_sh;
  logic signed [I_W-1:0]    mul_p;
  logic signed [DIFF_W-1:0] d_na_c, d_k_c, d_l_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [I_W-1:0]    dv_c;
  logic signed [UPD_W-1:0]  v_sum_c;
  logic signed [V_W-1:0]    v_next_c;

  assign accept   = in_valid && in_ready_q;
  assign in_ready = in_ready_q;
  assign v_out    = v_q;
  assign v_valid  = v_valid_q;
  assign spike    = spike_q;

  // State, step counter and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      v_valid_q  <= 1'b0;
      spike_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      v_valid_q  <= v_valid_d;
      spike_q    <= spike_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v_valid_d = 1'b0;
    spike_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MUL;
          cnt_d   = '0;
        end
      end
      ST_MUL: begin
        if (cnt_q == STEP_LAST) state_d = ST_SUM;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SUM: state_d = ST_UPD;
      ST_UPD: begin
        state_d   = ST_IDLE;
        v_valid_d = 1'b1;
        spike_d   = (v_snap_q < SPIKE_TH) && (v_next_c >= SPIKE_TH);
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Driving-force differences, kept wide enough that they never wrap.
  always_comb begin
    d_na_c = DIFF_W'(v_snap_q) - DIFF_W'(E_NA);
    d_k_c  = DIFF_W'(v_snap_q) - DIFF_W'(E_K);
    d_l_c  = DIFF_W'(v_snap_q) - DIFF_W'(E_L);
  end

  // Multiplier operand schedule: m^3*h*gNa*(V-ENA), n^4*gK*(V-EK), gL*(V-EL).
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    mul_sh = SH_16;
    if (state_q == ST_MUL) begin
      unique case (cnt_q)
        4'd0:    begin mul_a = OP_W'(gate_q.m);  mul_b = OP_W'(gate_q.m); end
        4'd1:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(gate_q.m); end
        4'd2:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(gate_q.h); end
        4'd3:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(G_NA);     end
        4'd4:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(d_na_c);   mul_sh = SH_8; end
        4'd5:    begin mul_a = OP_W'(gate_q.n);  mul_b = OP_W'(gate_q.n); end
        4'd6:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(gate_q.n); end
        4'd7:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(gate_q.n); end
        4'd8:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(G_K);      end
        4'd9:    begin mul_a = OP_W'(mul_p);     mul_b = OP_W'(d_k_c);    mul_sh = SH_8; end
        4'd10:   begin mul_a = OP_W'(G_L);       mul_b = OP_W'(d_l_c);    mul_sh = SH_8; end
        default: begin mul_a = '0;               mul_b = '0;              end
      endcase
    end
  end

  hh_fx_mul u_mul (
    .clk   (clk),
    .reset (reset),
    .a     (mul_a),
    .b     (mul_b),
    .sh    (mul_sh),
    .p     (mul_p)
  );

  // Total current and the clamped Euler update.
  always_comb begin
    sum_c   = SUM_W'(gate_q.i_ext) - SUM_W'(i_na_q) - SUM_W'(i_k_q) - SUM_W'(i_l_q);
    dv_c    = i_tot_q >>> DT_SHIFT;
    v_sum_c = UPD_W'(v_snap_q) + UPD_W'(dv_c);
    if (v_sum_c > UPD_W'(V_MAX))      v_next_c = V_MAX;
    else if (v_sum_c < UPD_W'(V_MIN)) v_next_c = V_MIN;
    else                              v_next_c = V_W'(v_sum_c);
  end

  // Sample capture, current captures and membrane potential register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_q   <= '0;
      v_snap_q <= V_REST;
      i_na_q   <= '0;
      i_k_q    <= '0;
      i_l_q    <= '0;
      i_tot_q  <= '0;
      v_q      <= V_REST;
    end else begin
      if (accept) begin
        gate_q   <= '{m: m_in, h: h_in, n: n_in, i_ext: i_ext};
        v_snap_q <= v_q;
      end
      if (state_q == ST_MUL) begin
        if (cnt_q == STEP_NA_CAP) i_na_q <= mul_p;
        if (cnt_q == STEP_K_CAP)  i_k_q  <= mul_p;
        if (cnt_q == STEP_LAST)   i_l_q  <= mul_p;
      end
      if (state_q == ST_SUM) i_tot_q <= sat_i(sum_c);
      if (state_q == ST_UPD) v_q     <= v_next_c;
    end
  end

endmodule

// File: tb/tb_hh_membrane_update.sv
// Self-checking bench for hh_membrane_update against a plain-arithmetic HH step model.
module tb_hh_membrane_update;

  localparam longint V_REST_C = -16640;
  localparam longint V_MIN_C  = -25600;
  localparam longint V_MAX_C  = 15360;
  localparam longint I_MAX_C  = 8388607;
  localparam longint I_MIN_C  = -8388608;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] m_in, h_in, n_in;
  logic [23:0] i_ext;
  logic [15:0] v_out;
  logic        v_valid;
  logic        spike;

  int     tests = 0;
  int     fails = 0;
  longint mv;

  typedef struct {
    int     m;
    int     h;
    int     n;
    int     ie;
    longint exp_v;
    bit     exp_spk;
  } vec_t;

  vec_t tbl[6];

  hh_membrane_update dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .m_in     (m_in),
    .h_in     (h_in),
    .n_in     (n_in),
    .i_ext    (i_ext),
    .v_out    (v_out),
    .v_valid  (v_valid),
    .spike    (spike)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One Euler step computed directly from the HH current equations.
  function automatic void hh_model(input longint v, input longint m, input longint h,
                                   input longint n, input longint ie,
                                   output longint vn, output bit spk);
    longint g, ina, ik, il, it;
    g   = (m * m) >>> 16;
    g   = (g * m) >>> 16;
    g   = (g * h) >>> 16;
    g   = (g * 30720) >>> 16;
    ina = (g * (v - 12800)) >>> 8;
    g   = (n * n) >>> 16;
    g   = (g * n) >>> 16;
    g   = (g * n) >>> 16;
    g   = (g * 9216) >>> 16;
    ik  = (g * (v + 19712)) >>> 8;
    il  = (77 * (v + 13923)) >>> 8;
    it  = ie - ina - ik - il;
    if (it > I_MAX_C) it = I_MAX_C;
    if (it < I_MIN_C) it = I_MIN_C;
    vn  = v + (it >>> 6);
    if (vn > V_MAX_C) vn = V_MAX_C;
    if (vn < V_MIN_C) vn = V_MIN_C;
    spk = (v < 0) && (vn >= 0);
  endfunction

  function automatic longint vo();
    return longint'($signed(v_out));
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mv = V_REST_C;
  endtask

  // Send one sample, wait for v_valid, check latency, result, spike and busy behaviour.
  task automatic do_step(input int m, input int h, input int n, input int ie,
                         input longint ev, input bit es, input string tag);
    int cyc;
    bit got, busy_ok, stray;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_ready"}, longint'(in_ready), 1);
    m_in = 16'(m); h_in = 16'(h); n_in = 16'(n); i_ext = 24'(ie);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_in = 16'($urandom); h_in = 16'($urandom); n_in = 16'($urandom); i_ext = 24'($urandom);
    cyc = 0; got = 1'b0; busy_ok = 1'b1; stray = 1'b0;
    while (!got && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (v_valid) got = 1'b1;
      else begin
        if (in_ready) busy_ok = 1'b0;
        if (spike)    stray = 1'b1;
      end
    end
    chk({tag, "_latency"}, cyc, 14);
    chk({tag, "_v"}, vo(), ev);
    chk({tag, "_spike"}, longint'(spike), longint'(es));
    chk({tag, "_busy"}, longint'({busy_ok, stray}), 2);
  endtask

  // Model the step, then run it on the DUT.
  task automatic step_m(input int m, input int h, input int n, input int ie, input string tag);
    longint ev;
    bit es;
    hh_model(mv, m, h, n, ie, ev, es);
    do_step(m, h, n, ie, ev, es, tag);
    mv = ev;
  endtask

  initial begin
    longint vchain, ev, d;
    bit     es;
    int     acc_n, vv_n, rdy_hi, last;
    bit     gap_ok, rdy;

    tbl[0] = '{3473, 39059, 20840, 2560, 0, 0};
    tbl[1] = '{6000, 30000, 22000, 25600, 0, 0};
    tbl[2] = '{20000, 20000, 30000, -25600, 0, 0};
    tbl[3] = '{65535, 65535, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 65535, 0, 0, 0};
    tbl[5] = '{1000, 60000, 10000, 1000000, 0, 0};
    vchain = V_REST_C;
    for (int i = 0; i < 6; i++) begin
      hh_model(vchain, tbl[i].m, tbl[i].h, tbl[i].n, tbl[i].ie, ev, es);
      tbl[i].exp_v   = ev;
      tbl[i].exp_spk = es;
      vchain = ev;
    end

    in_valid = 1'b0; m_in = '0; h_in = '0; n_in = '0; i_ext = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_v", vo(), V_REST_C);
    chk("reset_valid", longint'(v_valid), 0);
    chk("reset_spike", longint'(spike), 0);
    chk("reset_ready", longint'(in_ready), 1);
    reset = 1'b1;
    mv = V_REST_C;

    // Resting point stays nearly still
    step_m(3473, 39059, 20840, 0, "rest");
    d = vo() - V_REST_C;
    if (d < 0) d = -d;
    chk("rest_dv_small", longint'(d <= 8), 1);

    // Table vectors from rest
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_step(tbl[i].m, tbl[i].h, tbl[i].n, tbl[i].ie, tbl[i].exp_v, tbl[i].exp_spk,
              $sformatf("tbl%0d", i));
      mv = tbl[i].exp_v;
    end

    // Continuous in_valid: accepts every 15 clocks
    m_in = 16'd3473; h_in = 16'd39059; n_in = 16'd20840; i_ext = 24'd5000;
    in_valid = 1'b1;
    acc_n = 0; vv_n = 0; rdy_hi = 0; last = -1; gap_ok = 1'b1;
    for (int c = 0; c < 45; c++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        if (last >= 0 && c - last != 15) gap_ok = 1'b0;
        last = c;
        acc_n++;
      end
      if (in_ready) rdy_hi++;
      if (v_valid) vv_n++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hh_model(mv, 3473, 39059, 20840, 5000, ev, es);
      mv = ev;
    end
    chk("hs_accepts", acc_n, 3);
    chk("hs_gap15", longint'(gap_ok), 1);
    chk("hs_vvalid", vv_n, 3);
    chk("hs_ready_high", rdy_hi, 3);
    chk("hs_v", vo(), mv);

    // Positive saturation: clamps at V_MAX and holds there
    do_reset();
    step_m(0, 0, 0, 8388607, "satp0");
    chk("satp0_cross_spike", longint'(spike), 1);
    step_m(0, 0, 0, 8388607, "satp1");
    step_m(0, 0, 0, 8388607, "satp2");
    chk("satp_clamp", vo(), 15360);

    // Negative saturation
    step_m(0, 0, 0, -8388608, "satn0");
    step_m(0, 0, 0, -8388608, "satn1");
    chk("satn_clamp", vo(), -25600);

    // Spike: rest -> -256 -> 44 (crossing) -> 54 (stays above)
    do_reset();
    step_m(0, 0, 0, 1047758, "spk0");
    chk("spk0_v_hand", vo(), -256);
    step_m(0, 0, 0, 23310, "spk1");
    chk("spk1_spike_hand", longint'(spike), 1);
    chk("spk1_v_hand", vo(), 44);
    step_m(0, 0, 0, 4840, "spk2");
    chk("spk2_nospike_hand", longint'(spike), 0);

    // Abort: reset during MUL step 5 kills the step
    while (!in_ready) begin @(posedge clk); #1; end
    m_in = 16'd20000; h_in = 16'd20000; n_in = 16'd20000; i_ext = 24'd2000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_v", vo(), V_REST_C);
    chk("abort_valid", longint'(v_valid), 0);
    chk("abort_spike", longint'(spike), 0);
    chk("abort_ready", longint'(in_ready), 1);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    mv = V_REST_C;
    vv_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (v_valid) vv_n++;
    end
    chk("abort_no_valid", vv_n, 0);
    step_m(3473, 39059, 20840, 0, "abort_next");

    // Random stimulus against the model
    for (int i = 0; i < 25; i++) begin
      step_m(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 400000)) - 200000,
             $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
